// File: rtl/fb_writer_if.sv
// Pixel stream and framebuffer write port of fb_writer.
// The pixel source and the write-side observer use the master view; the writer uses the slave view.
interface fb_writer_if #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 14
);

  // Incoming pixel stream
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_sof;
  logic                  s_ready;

  // Framebuffer write port
  logic [DATA_WIDTH-1:0] wdata;
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  we;

  modport master (
    output s_data,
    output s_valid,
    output s_sof,
    input  s_ready,
    input  wdata,
    input  waddr,
    input  we
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_sof,
    output s_ready,
    output wdata,
    output waddr,
    output we
  );

endinterface

// File: rtl/fb_writer.sv
// Double-buffered framebuffer writer.
// Accepts a pixel stream framed by s_sof, writes each frame into the current
// write buffer, then waits for the display reader's frame_start before it
// swaps buffers and accepts the next frame.
module fb_writer #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 14,
  parameter int PIXELS     = 16384
) (
  input  logic        clk,
  input  logic        rst,
  fb_writer_if.slave  s,
  input  logic        frame_start,
  output logic        selection,
  output logic        swap_pending,
  output logic        frame_err,
  output logic [7:0]  frames_done
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    WAIT_SWAP
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIXELS - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic                  sel_q, sel_d;
  logic [7:0]            frames_q, frames_d;

  logic                  ready;
  logic                  accept;

  // State register and registered write-port / status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      sel_q    <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      sel_q    <= sel_d;
      frames_q <= frames_d;
    end
  end

  // Next-state and next-write decode for each accepted beat
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    err_d    = 1'b0;
    sel_d    = sel_q;
    frames_d = frames_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (s.s_sof) begin
            we_d    = 1'b1;
            waddr_d = '0;
            wdata_d = s.s_data;
            cnt_d   = ONE_ADDR;
            state_d = WRITE;
          end else begin
            // Beat outside any frame: drop it and flag the framing error
            err_d = 1'b1;
          end
        end
      end

      WRITE: begin
        if (accept) begin
          we_d    = 1'b1;
          wdata_d = s.s_data;
          if (s.s_sof) begin
            // Early start of frame: restart the frame from pixel 0
            waddr_d = '0;
            cnt_d   = ONE_ADDR;
            err_d   = 1'b1;
          end else begin
            waddr_d = cnt_q;
            if (cnt_q == LAST_ADDR) begin
              cnt_d   = '0;
              state_d = WAIT_SWAP;
            end else begin
              cnt_d = cnt_q + ONE_ADDR;
            end
          end
        end
      end

      WAIT_SWAP: begin
        // Entered only on the edge after the last beat, so the swap can never
        // precede the commit of the final pixel into the old write buffer
        if (frame_start) begin
          sel_d    = ~sel_q;
          frames_d = frames_q + 8'd1;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake and status outputs decoded from the current state
  always_comb begin
    ready        = ~rst && (state_q != WAIT_SWAP);
    accept       = s.s_valid && ready;
    swap_pending = (state_q == WAIT_SWAP);
  end

  assign s.s_ready   = ready;
  assign s.we        = we_q;
  assign s.waddr     = waddr_q;
  assign s.wdata     = wdata_q;
  assign selection   = sel_q;
  assign frame_err   = err_q;
  assign frames_done = frames_q;

endmodule

// File: tb/tb_fb_writer.sv
// Directed self-checking bench for fb_writer with a 4-pixel frame.
module tb_fb_writer;

  localparam int DW = 20;
  localparam int AW = 14;
  localparam int NP = 4;

  logic       clk;
  logic       rst;
  logic       frame_start;
  logic       selection;
  logic       swap_pending;
  logic       frame_err;
  logic [7:0] frames_done;

  int errors = 0;
  int checks = 0;

  fb_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fb_writer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .PIXELS    (NP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s           (bus),
    .frame_start (frame_start),
    .selection   (selection),
    .swap_pending(swap_pending),
    .frame_err   (frame_err),
    .frames_done (frames_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%0h exp=0", bus.s_ready); end
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL rst_we got=%0h exp=0", bus.we); end
    checks++; if (bus.waddr !== '0) begin errors++; $display("FAIL rst_waddr got=%0h exp=0", bus.waddr); end
    checks++; if (bus.wdata !== '0) begin errors++; $display("FAIL rst_wdata got=%0h exp=0", bus.wdata); end
    checks++; if (selection !== 1'b0) begin errors++; $display("FAIL rst_sel got=%0h exp=0", selection); end
    checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL rst_pending got=%0h exp=0", swap_pending); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%0h exp=0", frame_err); end
    checks++; if (frames_done !== 8'd0) begin errors++; $display("FAIL rst_frames got=%0d exp=0", frames_done); end
    rst = 1'b0;
    #1;
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got=%0h exp=1", bus.s_ready); end
  endtask

  task automatic test_full_frame();
    logic [DW-1:0] d;
    for (int i = 0; i < NP; i++) begin
      d = DW'(32'h1A000 + i);
      bus.s_valid = 1'b1;
      bus.s_sof   = (i == 0);
      bus.s_data  = d;
      checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL ff_ready[%0d] got=%0h exp=1", i, bus.s_ready); end
      tick();
      checks++; if (bus.we !== 1'b1) begin errors++; $display("FAIL ff_we[%0d] got=%0h exp=1", i, bus.we); end
      checks++; if (bus.waddr !== AW'(i)) begin errors++; $display("FAIL ff_waddr[%0d] got=%0d exp=%0d", i, bus.waddr, i); end
      checks++; if (bus.wdata !== d) begin errors++; $display("FAIL ff_wdata[%0d] got=%0h exp=%0h", i, bus.wdata, d); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ff_err[%0d] got=%0h exp=0", i, frame_err); end
    end
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL ff_pending got=%0h exp=1", swap_pending); end
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL ff_ready_wait got=%0h exp=0", bus.s_ready); end
    checks++; if (selection !== 1'b0) begin errors++; $display("FAIL ff_sel_pre got=%0h exp=0", selection); end
    tick();
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL ff_we_idle got=%0h exp=0", bus.we); end
    checks++; if (bus.waddr !== AW'(3)) begin errors++; $display("FAIL ff_waddr_hold got=%0d exp=3", bus.waddr); end
    checks++; if (bus.wdata !== DW'(32'h1A003)) begin errors++; $display("FAIL ff_wdata_hold got=%0h exp=1a003", bus.wdata); end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++; if (selection !== 1'b1) begin errors++; $display("FAIL ff_sel got=%0h exp=1", selection); end
    checks++; if (frames_done !== 8'd1) begin errors++; $display("FAIL ff_frames got=%0d exp=1", frames_done); end
    checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL ff_pending_clr got=%0h exp=0", swap_pending); end
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL ff_ready_after got=%0h exp=1", bus.s_ready); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < NP; i++) begin
      bus.s_valid = 1'b1;
      bus.s_sof   = (i == 0);
      bus.s_data  = DW'(32'h2B000 + i);
      tick();
      checks++; if (bus.waddr !== AW'(i)) begin errors++; $display("FAIL bp_waddr[%0d] got=%0d exp=%0d", i, bus.waddr, i); end
    end
    bus.s_sof  = 1'b0;
    bus.s_data = DW'(32'hBAD00);
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got=%0h exp=0", c, bus.s_ready); end
      checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL bp_we[%0d] got=%0h exp=0", c, bus.we); end
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after got=%0h exp=1", bus.s_ready); end
    checks++; if (selection !== 1'b0) begin errors++; $display("FAIL bp_sel got=%0h exp=0", selection); end
    checks++; if (frames_done !== 8'd2) begin errors++; $display("FAIL bp_frames got=%0d exp=2", frames_done); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL bp_err got=%0h exp=0", frame_err); end
    bus.s_valid = 1'b0;
  endtask

  task automatic test_resync();
    logic          sof_v [7];
    int unsigned   addr_v[7];
    logic          err_v [7];
    logic [DW-1:0] d;
    sof_v  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    addr_v = '{0, 1, 2, 0, 1, 2, 3};
    err_v  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      d = DW'(32'h3C000 + i);
      bus.s_valid = 1'b1;
      bus.s_sof   = sof_v[i];
      bus.s_data  = d;
      checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL rs_ready[%0d] got=%0h exp=1", i, bus.s_ready); end
      tick();
      checks++; if (bus.we !== 1'b1) begin errors++; $display("FAIL rs_we[%0d] got=%0h exp=1", i, bus.we); end
      checks++; if (bus.waddr !== AW'(addr_v[i])) begin errors++; $display("FAIL rs_waddr[%0d] got=%0d exp=%0d", i, bus.waddr, addr_v[i]); end
      checks++; if (bus.wdata !== d) begin errors++; $display("FAIL rs_wdata[%0d] got=%0h exp=%0h", i, bus.wdata, d); end
      checks++; if (frame_err !== err_v[i]) begin errors++; $display("FAIL rs_err[%0d] got=%0h exp=%0h", i, frame_err, err_v[i]); end
      checks++; if (swap_pending !== (i == 6)) begin errors++; $display("FAIL rs_pending[%0d] got=%0h exp=%0h", i, swap_pending, (i == 6)); end
    end
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++; if (selection !== 1'b1) begin errors++; $display("FAIL rs_sel got=%0h exp=1", selection); end
    checks++; if (frames_done !== 8'd3) begin errors++; $display("FAIL rs_frames got=%0d exp=3", frames_done); end
  endtask

  task automatic test_orphan();
    bus.s_valid = 1'b1;
    bus.s_sof   = 1'b0;
    bus.s_data  = DW'(32'h4D000);
    tick();
    bus.s_valid = 1'b0;
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL or_err got=%0h exp=1", frame_err); end
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL or_we got=%0h exp=0", bus.we); end
    checks++; if (bus.waddr !== AW'(3)) begin errors++; $display("FAIL or_waddr_hold got=%0d exp=3", bus.waddr); end
    checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL or_pending got=%0h exp=0", swap_pending); end
    tick();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL or_err_pulse got=%0h exp=0", frame_err); end
    // A second orphan proves the state stayed IDLE (WRITE would accept it as pixel data)
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL or_err2 got=%0h exp=1", frame_err); end
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL or_we2 got=%0h exp=0", bus.we); end
    tick();
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 2; i++) begin
      bus.s_valid = 1'b1;
      bus.s_sof   = (i == 0);
      bus.s_data  = DW'(32'h5E000 + i);
      tick();
    end
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    rst = 1'b1;
    tick();
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL mr_ready got=%0h exp=0", bus.s_ready); end
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL mr_we got=%0h exp=0", bus.we); end
    checks++; if (bus.waddr !== '0) begin errors++; $display("FAIL mr_waddr got=%0d exp=0", bus.waddr); end
    checks++; if (bus.wdata !== '0) begin errors++; $display("FAIL mr_wdata got=%0h exp=0", bus.wdata); end
    checks++; if (selection !== 1'b0) begin errors++; $display("FAIL mr_sel got=%0h exp=0", selection); end
    checks++; if (frames_done !== 8'd0) begin errors++; $display("FAIL mr_frames got=%0d exp=0", frames_done); end
    checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL mr_pending got=%0h exp=0", swap_pending); end
    rst = 1'b0;
    for (int i = 0; i < NP; i++) begin
      bus.s_valid = 1'b1;
      bus.s_sof   = (i == 0);
      bus.s_data  = DW'(32'h5F000 + i);
      tick();
      checks++; if (bus.waddr !== AW'(i)) begin errors++; $display("FAIL mr_waddr[%0d] got=%0d exp=%0d", i, bus.waddr, i); end
      checks++; if (bus.we !== 1'b1) begin errors++; $display("FAIL mr_we[%0d] got=%0h exp=1", i, bus.we); end
      checks++; if (selection !== 1'b0) begin errors++; $display("FAIL mr_sel[%0d] got=%0h exp=0", i, selection); end
    end
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL mr_pending_end got=%0h exp=1", swap_pending); end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++; if (selection !== 1'b1) begin errors++; $display("FAIL mr_sel_swap got=%0h exp=1", selection); end
    checks++; if (frames_done !== 8'd1) begin errors++; $display("FAIL mr_frames_swap got=%0d exp=1", frames_done); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < NP; i++) begin
      bus.s_valid = 1'b1;
      bus.s_sof   = (i == 0);
      bus.s_data  = DW'(32'h6A000 + i);
      frame_start = (i == NP - 1);
      tick();
    end
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    frame_start = 1'b0;
    checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL sim_pending got=%0h exp=1", swap_pending); end
    checks++; if (selection !== 1'b1) begin errors++; $display("FAIL sim_sel got=%0h exp=1", selection); end
    checks++; if (frames_done !== 8'd1) begin errors++; $display("FAIL sim_frames got=%0d exp=1", frames_done); end
    tick();
    checks++; if (selection !== 1'b1) begin errors++; $display("FAIL sim_sel_hold got=%0h exp=1", selection); end
    checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL sim_pending_hold got=%0h exp=1", swap_pending); end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++; if (selection !== 1'b0) begin errors++; $display("FAIL sim_sel_swap got=%0h exp=0", selection); end
    checks++; if (frames_done !== 8'd2) begin errors++; $display("FAIL sim_frames_swap got=%0d exp=2", frames_done); end
    checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL sim_pending_clr got=%0h exp=0", swap_pending); end
  endtask

  initial begin
    rst         = 1'b1;
    frame_start = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    bus.s_data  = '0;

    test_reset();
    test_full_frame();
    test_backpressure();
    test_resync();
    test_orphan();
    test_mid_reset();
    test_simultaneous();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
